// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard controller with multi-cycle load latency, $zero exemption,
// rt-use qualifier and branch-flush priority. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  branch_taken,
  output logic                  ex_ctrl_mux_ctrl,
  output logic                  if_id_pipe_enable,
  output logic                  pc_write_enable,
  output logic                  if_id_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hazard;
  logic          stall;

  // A load into $zero never produces a value worth waiting for; rt only matters if it is read.
  assign hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                  ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          stall = 1'b0;
        end else if (hazard) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_n = STALL;
            cnt_n   = CNT_INIT;
          end
        end
      end
      STALL: begin
        // ID/EX holds a bubble here, so only a taken branch can cut the wait short.
        if (branch_taken) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  assign ex_ctrl_mux_ctrl  = ~stall;
  assign if_id_pipe_enable = ~stall;
  assign pc_write_enable   = ~stall;
  assign if_id_flush       = branch_taken;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= sat_inc(stall_count, ~pc_write_enable);
      flush_count <= sat_inc(flush_count, if_id_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: four instances (LOAD_LAT 1/3/4, and CNT_W=2 with LOAD_LAT=2)
// share inputs; directed scenarios plus a random run against a stall-window model.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rt = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic       uses_rt = 1'b0;
  logic       br = 1'b0;

  logic ex_o[4];
  logic ifid_o[4];
  logic pc_o[4];
  logic fl_o[4];

  int n_chk = 0;
  int n_fail = 0;

  // Index: 0 -> LOAD_LAT=1, 1 -> LOAD_LAT=3, 2 -> LOAD_LAT=4, 3 -> CNT_W=2/LOAD_LAT=2
  int lat[4]    = '{1, 3, 4, 2};
  int cntmax[4] = '{65535, 65535, 65535, 3};

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] sc0, sc1, sc2, fc0, fc1, fc2;
  logic [1:0]  sc3, fc3;
  int got_sc[4];
  int got_fc[4];
  always_comb begin
    got_sc[0] = int'(sc0); got_sc[1] = int'(sc1); got_sc[2] = int'(sc2); got_sc[3] = int'(sc3);
    got_fc[0] = int'(fc0); got_fc[1] = int'(fc1); got_fc[2] = int'(fc2); got_fc[3] = int'(fc3);
  end
`endif

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .arst_n(arst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt), .branch_taken(br),
    .ex_ctrl_mux_ctrl(ex_o[0]), .if_id_pipe_enable(ifid_o[0]),
    .pc_write_enable(pc_o[0]), .if_id_flush(fl_o[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc0), .flush_count(fc0)
`endif
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) dut_l3 (
    .clk(clk), .arst_n(arst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt), .branch_taken(br),
    .ex_ctrl_mux_ctrl(ex_o[1]), .if_id_pipe_enable(ifid_o[1]),
    .pc_write_enable(pc_o[1]), .if_id_flush(fl_o[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(4), .CNT_W(16)) dut_l4 (
    .clk(clk), .arst_n(arst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt), .branch_taken(br),
    .ex_ctrl_mux_ctrl(ex_o[2]), .if_id_pipe_enable(ifid_o[2]),
    .pc_write_enable(pc_o[2]), .if_id_flush(fl_o[2])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc2), .flush_count(fc2)
`endif
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(2), .CNT_W(2)) dut_sat (
    .clk(clk), .arst_n(arst_n), .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt),
    .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(uses_rt), .branch_taken(br),
    .ex_ctrl_mux_ctrl(ex_o[3]), .if_id_pipe_enable(ifid_o[3]),
    .pc_write_enable(pc_o[3]), .if_id_flush(fl_o[3])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  function automatic logic [2:0] en_of(input int d);
    return {ex_o[d], ifid_o[d], pc_o[d]};
  endfunction

  task automatic set_in(input logic m, input int ert, input int s, input int t,
                        input logic u, input logic b);
    mem_read = m;
    ex_rt    = 5'(ert);
    rs       = 5'(s);
    rt       = 5'(t);
    uses_rt  = u;
    br       = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    set_in(1'b0, 0, 0, 0, 1'b0, 1'b0);
    #3;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (en_of(d) !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_en dut%0d got %b want 111", d, en_of(d));
      end
      n_chk++;
      if (fl_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flush dut%0d got %b want 0", d, fl_o[d]);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_chk++;
      if (got_sc[d] !== 0 || got_fc[d] !== 0) begin
        n_fail++;
        $display("FAIL reset_cnt dut%0d got %0d/%0d want 0/0", d, got_sc[d], got_fc[d]);
      end
`endif
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
  endtask

  task automatic test_lat1();
    do_reset();
    set_in(1'b1, 8, 8, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(0) !== 3'b000) begin
      n_fail++;
      $display("FAIL lat1_stall got %b want 000", en_of(0));
    end
    tick();
    set_in(1'b0, 0, 8, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(0) !== 3'b111) begin
      n_fail++;
      $display("FAIL lat1_release got %b want 111", en_of(0));
    end
    tick();
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (got_sc[0] !== 1) begin
      n_fail++;
      $display("FAIL lat1_stall_count got %0d want 1", got_sc[0]);
    end
`endif
  endtask

  task automatic test_lat3();
    do_reset();
    set_in(1'b1, 8, 8, 0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (en_of(1) !== ((c < 3) ? 3'b000 : 3'b111)) begin
        n_fail++;
        $display("FAIL lat3_cycle%0d got %b want %b", c, en_of(1), (c < 3) ? 3'b000 : 3'b111);
      end
      tick();
      set_in(1'b0, 0, 8, 0, 1'b0, 1'b0);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (got_sc[1] !== 3) begin
      n_fail++;
      $display("FAIL lat3_stall_count got %0d want 3", got_sc[1]);
    end
`endif
  endtask

  task automatic test_filter();
    do_reset();
    set_in(1'b1, 0, 0, 0, 1'b1, 1'b0);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (en_of(d) !== 3'b111) begin
        n_fail++;
        $display("FAIL filter_zero dut%0d got %b want 111", d, en_of(d));
      end
    end
    set_in(1'b1, 9, 1, 9, 1'b0, 1'b0);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if (en_of(d) !== 3'b111) begin
        n_fail++;
        $display("FAIL filter_rt_unused dut%0d got %b want 111", d, en_of(d));
      end
    end
    set_in(1'b1, 9, 1, 9, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (en_of(0) !== 3'b000) begin
      n_fail++;
      $display("FAIL filter_rt_used got %b want 000", en_of(0));
    end
    set_in(1'b0, 9, 9, 9, 1'b1, 1'b0);
    #1;
    n_chk++;
    if (en_of(0) !== 3'b111) begin
      n_fail++;
      $display("FAIL filter_no_load got %b want 111", en_of(0));
    end
  endtask

  task automatic test_branch_abort();
    do_reset();
    set_in(1'b1, 8, 8, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(2) !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_first got %b want 000", en_of(2));
    end
    tick();
    set_in(1'b0, 0, 8, 0, 1'b0, 1'b1);
    #1;
    n_chk++;
    if (en_of(2) !== 3'b111 || fl_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_branch got en=%b fl=%b want en=111 fl=1", en_of(2), fl_o[2]);
    end
    tick();
    set_in(1'b0, 0, 8, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(2) !== 3'b111 || fl_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after got en=%b fl=%b want en=111 fl=0", en_of(2), fl_o[2]);
    end
    tick();
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (got_sc[2] !== 1 || got_fc[2] !== 1) begin
      n_fail++;
      $display("FAIL abort_counts got stall=%0d flush=%0d want 1/1", got_sc[2], got_fc[2]);
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_in(1'b1, 8, 8, 0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 0, 8, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(2) !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_in_stall got %b want 000", en_of(2));
    end
    arst_n = 1'b0;
    #1;
    n_chk++;
    if (en_of(2) !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_mid_async got %b want 111", en_of(2));
    end
`ifdef HAZARD_PERF_CNT_EN
    n_chk++;
    if (got_sc[2] !== 0 || got_fc[2] !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_counts got %0d/%0d want 0/0", got_sc[2], got_fc[2]);
    end
`endif
    #2;
    arst_n = 1'b1;
    tick();
    #1;
    n_chk++;
    if (en_of(2) !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_mid_released got %b want 111", en_of(2));
    end
    set_in(1'b1, 5, 5, 0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (en_of(2) !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_new_hazard got %b want 000", en_of(2));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1'b1, 7, 7, 0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) set_in(1'b0, 7, 7, 0, 1'b0, 1'b0);
      #1;
      n_chk++;
      if (en_of(1) !== ((c < 6) ? 3'b000 : 3'b111)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got %b want %b", c, en_of(1), (c < 6) ? 3'b000 : 3'b111);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 3, 3, 0, 1'b0, 1'b0);
      #1;
      n_chk++;
      if (en_of(3) !== 3'b000) begin
        n_fail++;
        $display("FAIL sat_hazard%0d got %b want 000", k, en_of(3));
      end
      tick();
      set_in(1'b0, 0, 3, 0, 1'b0, 1'b0);
      #1;
      n_chk++;
      if (en_of(3) !== 3'b000) begin
        n_fail++;
        $display("FAIL sat_stall%0d got %b want 000", k, en_of(3));
      end
      tick();
`ifdef HAZARD_PERF_CNT_EN
      n_chk++;
      if (got_sc[3] !== ((k == 0) ? 2 : 3)) begin
        n_fail++;
        $display("FAIL sat_count%0d got %0d want %0d", k, got_sc[3], (k == 0) ? 2 : 3);
      end
`endif
    end
    #1;
    n_chk++;
    if (en_of(3) !== 3'b111) begin
      n_fail++;
      $display("FAIL sat_release got %b want 111", en_of(3));
    end
  endtask

  task automatic test_random();
    int  rem[4];
    int  sc[4];
    int  fc[4];
    bit  haz;
    bit  exp_en[4];
    do_reset();
    for (int d = 0; d < 4; d++) begin
      rem[d] = 0;
      sc[d]  = 0;
      fc[d]  = 0;
    end
    for (int c = 0; c < 300; c++) begin
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      #1;
      haz = mem_read && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
      for (int d = 0; d < 4; d++) begin
        // Enables drop only while a stall window is open and no branch overrides it.
        exp_en[d] = br || ((rem[d] == 0) && !haz);
        n_chk++;
        if (en_of(d) !== {3{exp_en[d]}} || fl_o[d] !== br) begin
          n_fail++;
          $display("FAIL rand_c%0d_dut%0d got en=%b fl=%b want en=%b fl=%b",
                   c, d, en_of(d), fl_o[d], {3{exp_en[d]}}, br);
        end
      end
      tick();
      for (int d = 0; d < 4; d++) begin
        if (br) rem[d] = 0;
        else if (rem[d] > 0) rem[d] = rem[d] - 1;
        else if (haz) rem[d] = lat[d] - 1;
        if (!exp_en[d] && sc[d] < cntmax[d]) sc[d]++;
        if (br && fc[d] < cntmax[d]) fc[d]++;
`ifdef HAZARD_PERF_CNT_EN
        n_chk++;
        if (got_sc[d] !== sc[d] || got_fc[d] !== fc[d]) begin
          n_fail++;
          $display("FAIL rand_cnt_c%0d_dut%0d got %0d/%0d want %0d/%0d",
                   c, d, got_sc[d], got_fc[d], sc[d], fc[d]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_lat3();
    test_filter();
    test_branch_abort();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Parametrised load-use hazard controller for the pipelined core, sitting between the IF/ID and ID/EX pipeline registers and driving PC write enable, IF/ID write enable, the EX control-zeroing mux and the IF/ID flush. It extends single-cycle load-use detection in four ways:
- multi-cycle data-memory read latency, via a stall FSM and down-counter;
- `$zero` exemption;
- an operand-use qualifier;
- branch-flush priority.

Optional performance counters report stall and flush activity.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_LAT, 1, total load-use stall cycles required (1..8); 1 gives the classic single bubble.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  reset, asynchronous, active-low.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- id_ex_rt  in  REG_ADDR_W  load destination register in ID/EX.
- if_id_rs  in  REG_ADDR_W  IF/ID source register rs.
- if_id_rt  in  REG_ADDR_W  IF/ID source register rt.
- if_id_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, branch).
- branch_taken  in  1  branch/jump resolved taken this cycle.
- ex_ctrl_mux_ctrl  out  1  0 = insert bubble (zero ID/EX control).
- if_id_pipe_enable  out  1  0 = hold IF/ID.
- pc_write_enable  out  1  0 = hold PC.
- if_id_flush  out  1  1 = clear IF/ID to NOP.
- stall_count  out  CNT_W  cycles with pc_write_enable=0 (only with HAZARD_PERF_CNT_EN).
- flush_count  out  CNT_W  cycles with if_id_flush=1 (only with HAZARD_PERF_CNT_EN).

## Operation
- hazard = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & id_ex_rt == if_id_rt)).
- FSM states: RUN, STALL. Counter `cnt` is ceil(log2(LOAD_LAT+1)) bits wide.
- RUN:
  - If branch_taken: if_id_flush=1, no stall, stay in RUN.
  - Else if hazard: stall this cycle (ex_ctrl_mux_ctrl = if_id_pipe_enable = pc_write_enable = 0).
    - If LOAD_LAT>1: go to STALL with cnt=LOAD_LAT-1.
    - Otherwise stay in RUN.
  - Else: all three enables = 1.
- STALL:
  - Enables held at 0 regardless of inputs; hazard is not re-evaluated because ID/EX now holds a bubble.
  - Each cycle cnt decrements.
  - When cnt==1 at a clock edge, the next state is RUN and the hazard is re-evaluated from RUN.
- branch_taken in STALL:
  - Aborts the stall: next state is RUN, cnt cleared.
  - That cycle, if_id_flush=1 and the enables are 1 (flush has priority over stall).
- if_id_flush is combinational from branch_taken in both states.
- Enables are 0 only on hazard or in STALL.

## Timing
- Reset (arst_n=0, asynchronous): state=RUN, cnt=0, counters=0.
  - Outputs then follow the RUN equations: with hazard=0 and branch_taken=0, the enables read 1 and if_id_flush reads 0.
- Detection latency is 0 cycles: stall outputs are combinational in the same cycle the load sits in ID/EX.
- Stall duration: exactly LOAD_LAT consecutive cycles with pc_write_enable=0 per load-use hazard, absent branch.
- Back-to-back loads: a new hazard on RUN re-entry starts a fresh LOAD_LAT window with no gap cycle required.
- Reset mid-STALL: returns immediately to RUN; no residual stall after release.
- Counters:
  - Increment on the clock edge for each qualifying cycle.
  - Saturate at 2^CNT_W-1; no wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_count and flush_count ports and registers exist, behaving as above.
- HAZARD_PERF_CNT_EN undefined: both ports and registers are removed. Hazard, stall and flush behaviour is identical either way.

## Test plan
- LOAD_LAT=1: mem_read=1, id_ex_rt=8, if_id_rs=8 -> enables 0 for exactly 1 cycle, then 1; stall_count=1.
- LOAD_LAT=3: same stimulus -> enables 0 for exactly 3 cycles, state returns to RUN; stall_count=3.
- False-hazard filter:
  - id_ex_rt=0, if_id_rs=0 -> no stall.
  - id_ex_rt=9, if_id_rt=9, if_id_uses_rt=0 -> no stall.
  - Same with if_id_uses_rt=1 -> stall.
- LOAD_LAT=4: branch_taken=1 in the 2nd stall cycle -> that cycle if_id_flush=1 and enables=1; next cycle RUN, no stall; flush_count=1, stall_count=1.
- LOAD_LAT=4: arst_n low in the 2nd stall cycle -> enables 1 immediately, counters 0; after release no stall unless the hazard is present.
- CNT_W=2, LOAD_LAT=2: three consecutive load-use hazards -> stall_count saturates at 3.
